// File: rtl/mdu_div_pkg.sv
// mdu_div_pkg: shared types and constants for the M-extension divide front-end.
//   div_op_e    : operation encoding (funct3[1:0])
//   div_state_e : control FSM states
//   DIV_W, DIV_ITERS, INT_MIN : width-dependent constants
//   abs_val()   : magnitude of an operand, honouring signedness
package mdu_div_pkg;

  localparam int          DIV_W     = 32;
  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_OUT  = 2'd3
  } div_state_e;

  // Two's complement of a negative signed operand; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DIV_W-1:0] abs_val(input logic [DIV_W-1:0] v,
                                               input logic             is_signed);
    if (is_signed && ((v & INT_MIN) != '0)) return -v;
    return v;
  endfunction

endpackage

// File: rtl/div_core.sv
// div_core: radix-2 restoring unsigned divider, one quotient bit per cycle.
// Ports:
//   clock, nreset       : clock / async active-low reset
//   start               : load dividend/divisor and begin (32 iterations)
//   abort               : stop immediately, counter back to 0
//   dividend, divisor   : unsigned operands, sampled on start
//   quotient, remainder : results, final from the cycle after done
//   done                : one-cycle pulse during the last iteration cycle
module div_core
  import mdu_div_pkg::*;
(
  input  logic             clock,
  input  logic             nreset,
  input  logic             start,
  input  logic             abort,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             done
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  logic [4:0]       cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [DIV_W-1:0] quo_q, quo_d;
  logic [DIV_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] dvs_q, dvs_d;
  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   trial;

  always_comb begin
    shifted = {rem_q, quo_q[DIV_W-1]};
    trial   = shifted - {1'b0, dvs_q};
    cnt_d   = cnt_q;
    run_d   = run_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    if (abort) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start) begin
      run_d = 1'b1;
      cnt_d = '0;
      quo_d = dividend;
      rem_d = '0;
      dvs_d = divisor;
    end else if (run_q) begin
      // Restoring step: keep the subtraction only if it did not borrow.
      if (!trial[DIV_W]) begin
        rem_d = trial[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b1};
      end else begin
        rem_d = shifted[DIV_W-1:0];
        quo_d = {quo_q[DIV_W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == LAST_ITER) run_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = run_q && (cnt_q == LAST_ITER);

endmodule

// File: rtl/mdu_div_ctrl.sv
// mdu_div_ctrl: DIV/DIVU/REM/REMU front-end with valid/ready handshake.
// Ports:
//   clock, nreset        : clock / async active-low reset
//   kill                 : synchronous flush of any in-flight operation
//   in_valid, in_ready   : request handshake (in_ready only in IDLE)
//   op, rs1, rs2         : operation (div_op_e), dividend, divisor
//   out_valid, out_ready : result handshake
//   result               : quotient or remainder, held while in OUT
//   busy                 : state is not IDLE
// Build option: DIV_FAST_PATH_EN sends divide-by-zero and |rs1|<|rs2|
// straight to OUT on accept without starting the core.
//
// state | meaning
// IDLE  | ready for a request; latch operands and start core on accept
// CALC  | core iterating (32 cycles)
// FIX   | apply sign correction / divide-by-zero override into result
// OUT   | result valid, held until out_ready
module mdu_div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  import mdu_div_pkg::*;

  div_state_e       state_q, state_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic             is_rem_q, is_rem_d;
  logic             div_zero_q, div_zero_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;

  div_op_e          op_e;
  logic             signed_op;
  logic [XLEN-1:0]  rs1_mag, rs2_mag;
  logic             rs2_zero;
  logic             fast;
  logic [XLEN-1:0]  fast_res;
  logic [XLEN-1:0]  fix_res;
  logic             core_start, core_abort, core_done;
  logic [XLEN-1:0]  core_quo, core_rem;

  assign op_e      = div_op_e'(op);
  assign signed_op = (op_e == OP_DIV) || (op_e == OP_REM);
  assign rs1_mag   = abs_val(rs1, signed_op);
  assign rs2_mag   = abs_val(rs2, signed_op);
  assign rs2_zero  = (rs2 == '0);

`ifdef DIV_FAST_PATH_EN
  assign fast     = rs2_zero || (rs1_mag < rs2_mag);
  // Either case leaves the remainder as rs1; only a zero-divide quotient is all ones.
  assign fast_res = op[1] ? rs1 : (rs2_zero ? '1 : '0);
`else
  assign fast     = 1'b0;
  assign fast_res = '0;
`endif

  always_comb begin
    if (div_zero_q)     fix_res = is_rem_q ? rs1_q : '1;
    else if (is_rem_q)  fix_res = rem_neg_q ? -core_rem : core_rem;
    else                fix_res = quo_neg_q ? -core_quo : core_quo;
  end

  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    rs1_d      = rs1_q;
    is_rem_d   = is_rem_q;
    div_zero_d = div_zero_q;
    quo_neg_d  = quo_neg_q;
    rem_neg_d  = rem_neg_q;
    core_start = 1'b0;
    core_abort = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !kill) begin
          rs1_d      = rs1;
          is_rem_d   = op[1];
          div_zero_d = rs2_zero;
          quo_neg_d  = signed_op && (rs1[XLEN-1] ^ rs2[XLEN-1]);
          rem_neg_d  = signed_op && rs1[XLEN-1];
          if (fast) begin
            result_d = fast_res;
            state_d  = ST_OUT;
          end else begin
            core_start = 1'b1;
            state_d    = ST_CALC;
          end
        end
      end
      ST_CALC: if (core_done) state_d = ST_FIX;
      ST_FIX: begin
        result_d = fix_res;
        state_d  = ST_OUT;
      end
      ST_OUT:  if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (kill) begin
      state_d    = ST_IDLE;
      result_d   = result_q;
      core_abort = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      rs1_q      <= '0;
      is_rem_q   <= 1'b0;
      div_zero_q <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      rs1_q      <= rs1_d;
      is_rem_q   <= is_rem_d;
      div_zero_q <= div_zero_d;
      quo_neg_q  <= quo_neg_d;
      rem_neg_q  <= rem_neg_d;
    end
  end

  div_core u_core (
    .clock     (clock),
    .nreset    (nreset),
    .start     (core_start),
    .abort     (core_abort),
    .dividend  (rs1_mag),
    .divisor   (rs2_mag),
    .quotient  (core_quo),
    .remainder (core_rem),
    .done      (core_done)
  );

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign result    = result_q;

endmodule

// File: tb/tb_mdu_div_ctrl.sv
module tb_mdu_div_ctrl;

  localparam int NORM = 34;
`ifdef DIV_FAST_PATH_EN
  localparam int FASTL = 1;
`else
  localparam int FASTL = 34;
`endif

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  logic        clock = 1'b0;
  logic        nreset;
  logic        kill;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  mdu_div_ctrl #(.XLEN(32)) dut (
    .clock     (clock),
    .nreset    (nreset),
    .kill      (kill),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", nm, act, req);
    end
  endtask

  // Monitor: on each new result presentation, pop the oldest expectation.
  exp_t mon_e;
  logic prev_v = 1'b0;
  always @(posedge clock) begin
    #1;
    if (out_valid === 1'b1 && prev_v !== 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out_valid: actual result %h required no output", result);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.name, "_result"}, result, mon_e.res);
        chk({mon_e.name, "_latency"}, 32'(cyc - mon_e.acc + 1), 32'(mon_e.lat));
      end
    end
    prev_v = out_valid;
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] exp, input int lat,
                       input string nm);
    exp_t e;
    int   n;
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (in_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_in_ready_timeout: actual in_ready %b required 1", nm, in_ready);
    end
    @(negedge clock);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    if (push) begin
      e.res = exp; e.lat = lat; e.acc = cyc + 1; e.name = nm;
      sb.push_back(e);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string nm);
    issue(o, a, b, 1'b1, exp, lat, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual time %0t required end of test earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    nreset = 1'b1; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; rs1 = '0; rs2 = '0;
    #2 nreset = 1'b0;
    #1;
    chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_result", result, 32'd0);
    repeat (3) @(negedge clock);
    nreset = 1'b1;

    run(DIVU, 32'd100, 32'd7, 32'd14, NORM, "divu_100_7");
    run(REMU, 32'd100, 32'd7, 32'd2, NORM, "remu_100_7");
    run(DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, NORM, "div_m100_7");
    run(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NORM, "rem_m100_7");
    run(REM, 32'd100, 32'hFFFF_FFF9, 32'd2, NORM, "rem_100_m7");
    run(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM, "div_ovf");
    run(REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, NORM, "rem_ovf");
    run(DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, FASTL, "divu_5_0");
    run(REM, 32'd5, 32'd0, 32'd5, FASTL, "rem_5_0");
    run(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, FASTL, "div_m5_0");
    run(REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, FASTL, "rem_m5_0");
    run(DIVU, 32'd3, 32'd10, 32'd0, FASTL, "divu_3_10");
    run(REMU, 32'd3, 32'd10, 32'd3, FASTL, "remu_3_10");
    run(REM, 32'hFFFF_FFFD, 32'd10, 32'hFFFF_FFFD, FASTL, "rem_m3_10");
    run(DIV, 32'hFFFF_FFFD, 32'd10, 32'd0, FASTL, "div_m3_10");
    run(DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORM, "divu_max_1");
    run(REMU, 32'hFFFF_FFFF, 32'd10, 32'd5, NORM, "remu_max_10");
    run(DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM, "div_7_m2");
    run(REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORM, "rem_7_m2");

    // Backpressure: result and handshake held while out_ready is low.
    n = 0;
    while (in_ready !== 1'b1 && n < 200) begin @(posedge clock); #1; n++; end
    out_ready = 1'b0;
    run(DIVU, 32'd100, 32'd7, 32'd14, NORM, "bp_divu_100_7");
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
    chk("bp_out_valid_seen", {31'b0, out_valid}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clock); #1;
      chk("bp_result_stable", result, 32'd14);
      chk("bp_out_valid_held", {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clock); out_ready = 1'b1;
    @(posedge clock); #1;
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);

    // Kill at cycle 10 of CALC: nothing should ever come out.
    issue(DIVU, 32'd1000, 32'd3, 1'b0, 32'd0, 0, "kill_victim");
    repeat (9) @(posedge clock);
    @(negedge clock); kill = 1'b1;
    @(posedge clock); #1; kill = 1'b0;
    chk("kill_in_ready", {31'b0, in_ready}, 32'd1);
    chk("kill_out_valid", {31'b0, out_valid}, 32'd0);
    chk("kill_busy", {31'b0, busy}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      chk("kill_no_out_valid", {31'b0, out_valid}, 32'd0);
    end
    // A request presented together with kill in IDLE must not be accepted.
    @(negedge clock);
    op = DIVU; rs1 = 32'd9; rs2 = 32'd3; in_valid = 1'b1; kill = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_no_accept", {31'b0, busy}, 32'd0);
    run(DIVU, 32'd9, 32'd3, 32'd3, NORM, "post_kill_divu_9_3");

    // Asynchronous reset in the middle of CALC.
    issue(DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, 0, "reset_victim");
    repeat (5) @(posedge clock);
    #2 nreset = 1'b0;
    #1;
    chk("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_result", result, 32'd0);
    repeat (2) @(negedge clock);
    nreset = 1'b1;
    run(DIVU, 32'd100, 32'd7, 32'd14, NORM, "post_reset_divu_100_7");
    run(REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, NORM, "post_reset_rem_m100_7");

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clock); #1; n++; end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: actual %0d pending required 0", sb.size());
    end
    repeat (2) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
